// File: rtl/rally_pkg.sv
// rally_pkg: shared game-flow state encodings and level constants
package rally_pkg;
   localparam int LVL_W = 2;
   localparam int NUM_LEVELS = 3;
   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      LOAD_RST    = 3'd1,
      LOAD_SETTLE = 3'd2,
      PLAY        = 3'd3,
      CLEAR       = 3'd4,
      GAME_OVER   = 3'd5,
      WIN         = 3'd6
   } state_t;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk down to a one-cycle game tick every DIV enabled cycles
module tick_prescaler #(
   parameter int DIV = 25_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);
   localparam int W = $clog2(DIV);
   logic [W-1:0] cnt;
   assign tick = en && cnt == W'(DIV - 1);
   // count enabled cycles, wrapping on the tick; clr discards a partial count
   always_ff @(posedge clk)
      if (rst || clr) cnt <= '0;
      else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/level_sequencer.sv
// level_sequencer: game-flow FSM sequencing level load, play, clear, lives and timer
module level_sequencer #(
   parameter int TICK_DIV    = 25_000_000,
   parameter int LEVEL_TIME  = 90,
   parameter int CLEAR_TICKS = 2,
   parameter int LIVES       = 3,
   parameter int NUM_LEVELS  = rally_pkg::NUM_LEVELS
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       all_collected,
   input  logic                       crash,
   output logic [rally_pkg::LVL_W-1:0] level_id,
   output logic                       level_rst,
   output logic                       play_active,
   output logic [2:0]                 game_state,
   output logic [7:0]                 time_left,
   output logic [1:0]                 lives
);
   import rally_pkg::*;
   localparam int CW = $clog2(CLEAR_TICKS + 1);
   state_t state, state_n;
   logic [LVL_W-1:0] level_n;
   logic [1:0] lives_n;
   logic [7:0] time_n;
   logic [CW-1:0] clear_cnt, clear_n;
   logic start_q, start_rise, tick, pclr;
   assign start_rise  = start & ~start_q;
   assign level_rst   = state == IDLE || state == LOAD_RST;
   assign play_active = state == PLAY;
   assign game_state  = state;
   tick_prescaler #(.DIV(TICK_DIV)) u_presc (
      .clk (clk),
      .rst (rst),
      .clr (pclr),
      .en  (state == PLAY || state == CLEAR),
      .tick(tick)
   );
   // register FSM state and the HUD counters
   always_ff @(posedge clk)
      if (rst) begin
         state     <= IDLE;
         level_id  <= '0;
         lives     <= '0;
         time_left <= '0;
         clear_cnt <= '0;
         start_q   <= 1'b0;
      end else begin
         state     <= state_n;
         level_id  <= level_n;
         lives     <= lives_n;
         time_left <= time_n;
         clear_cnt <= clear_n;
         start_q   <= start;
      end
   // next-state and counter updates; a clear in PLAY outranks crash and timeout
   always_comb begin
      state_n = state;
      level_n = level_id;
      lives_n = lives;
      time_n  = time_left;
      clear_n = clear_cnt;
      pclr    = 1'b0;
      case (state)
         IDLE, GAME_OVER, WIN:
            if (start_rise) begin
               level_n = LVL_W'(1);
               lives_n = 2'(LIVES);
               state_n = LOAD_RST;
            end
         LOAD_RST: begin
            time_n  = 8'(LEVEL_TIME);
            pclr    = 1'b1;
            state_n = LOAD_SETTLE;
         end
         LOAD_SETTLE: state_n = PLAY;
         PLAY:
            if (all_collected) begin
               pclr    = 1'b1;
               clear_n = CW'(CLEAR_TICKS);
               state_n = CLEAR;
            end else begin
               if (tick && time_left != 8'd0) time_n = time_left - 1'b1;
               if (crash || (tick && time_left == 8'd1)) begin
                  lives_n = lives <= 2'd1 ? 2'd0 : lives - 1'b1;
                  state_n = lives <= 2'd1 ? GAME_OVER : LOAD_RST;
               end
            end
         CLEAR:
            if (tick) begin
               clear_n = clear_cnt <= CW'(1) ? '0 : clear_cnt - 1'b1;
               if (clear_cnt <= CW'(1)) begin
                  state_n = level_id == LVL_W'(NUM_LEVELS) ? WIN : LOAD_RST;
                  level_n = level_id == LVL_W'(NUM_LEVELS) ? level_id : level_id + 1'b1;
               end
            end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_level_sequencer.sv
// tb_level_sequencer: directed self-checking bench for the game-flow sequencer
module tb_level_sequencer;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, all_collected = 1'b0, crash = 1'b0;
   logic [1:0] level_id, lives;
   logic level_rst, play_active;
   logic [2:0] game_state;
   logic [7:0] time_left;
   int n_vec = 0, n_err = 0;

   level_sequencer #(
      .TICK_DIV(4), .LEVEL_TIME(5), .CLEAR_TICKS(2), .LIVES(3), .NUM_LEVELS(3)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .all_collected(all_collected), .crash(crash),
      .level_id(level_id), .level_rst(level_rst), .play_active(play_active),
      .game_state(game_state), .time_left(time_left), .lives(lives)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_hud(input string tag, input int st, input int lvl, input int lv, input int tl);
      check({tag, ".state"}, game_state, st);
      check({tag, ".level"}, level_id, lvl);
      check({tag, ".lives"}, lives, lv);
      check({tag, ".time"}, time_left, tl);
   endtask

   task automatic crash_once(input string tag, input int st, input int lv);
      step(2);
      check({tag, ".play"}, game_state, 3);
      crash = 1'b1;
      step(1);
      crash = 1'b0;
      check({tag, ".state"}, game_state, st);
      check({tag, ".lives"}, lives, lv);
   endtask

   initial begin
      step(2);
      expect_hud("rst", 0, 0, 0, 0);
      check("rst.level_rst", level_rst, 1);
      check("rst.play_active", play_active, 0);
      rst = 1'b0;
      step(1);
      check("idle.state", game_state, 0);
      // first game start
      start = 1'b1;
      step(1);
      start = 1'b0;
      expect_hud("start", 1, 1, 3, 0);
      check("start.level_rst", level_rst, 1);
      step(1);
      check("settle.state", game_state, 2);
      check("settle.level_rst", level_rst, 0);
      check("settle.time", time_left, 5);
      step(1);
      check("play.state", game_state, 3);
      check("play.active", play_active, 1);
      // clear level 1, then 2, then 3 -> WIN
      all_collected = 1'b1;
      step(1);
      all_collected = 1'b0;
      check("clr1.state", game_state, 4);
      check("clr1.active", play_active, 0);
      check("clr1.time", time_left, 5);
      step(7);
      check("clr1.hold", game_state, 4);
      step(1);
      expect_hud("lvl2", 1, 2, 3, 5);
      step(2);
      all_collected = 1'b1;
      step(1);
      all_collected = 1'b0;
      check("clr2.state", game_state, 4);
      step(8);
      expect_hud("lvl3", 1, 3, 3, 5);
      step(2);
      all_collected = 1'b1;
      step(1);
      all_collected = 1'b0;
      step(8);
      expect_hud("win", 6, 3, 3, 5);
      step(3);
      check("win.hold", game_state, 6);
      check("win.level", level_id, 3);
      // new game, timeout
      start = 1'b1;
      step(1);
      start = 1'b0;
      expect_hud("restart", 1, 1, 3, 5);
      step(2);
      check("to.play", game_state, 3);
      step(3);
      check("to.t5", time_left, 5);
      step(1);
      check("to.t4", time_left, 4);
      step(4);
      check("to.t3", time_left, 3);
      step(4);
      check("to.t2", time_left, 2);
      step(4);
      check("to.t1", time_left, 1);
      check("to.still_play", game_state, 3);
      step(4);
      expect_hud("timeout", 1, 1, 2, 0);
      // crashes to game over
      crash_once("c1", 1, 1);
      crash_once("c2", 5, 0);
      expect_hud("gover", 5, 1, 0, 5);
      step(3);
      check("gover.hold", game_state, 5);
      start = 1'b1;
      step(1);
      start = 1'b0;
      expect_hud("restart2", 1, 1, 3, 5);
      // clear beats crash in the same cycle
      step(2);
      all_collected = 1'b1;
      crash = 1'b1;
      step(1);
      crash = 1'b0;
      all_collected = 1'b0;
      check("tie.state", game_state, 4);
      check("tie.lives", lives, 3);
      step(8);
      check("tie.next", game_state, 1);
      check("tie.level", level_id, 2);
      // stale all_collected through load is ignored until PLAY
      all_collected = 1'b1;
      step(1);
      check("stale.settle", game_state, 2);
      step(1);
      check("stale.play", game_state, 3);
      step(1);
      all_collected = 1'b0;
      check("stale.clear", game_state, 4);
      // reset mid-clear
      step(3);
      check("midclr.state", game_state, 4);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      expect_hud("midrst", 0, 0, 0, 0);
      check("midrst.level_rst", level_rst, 1);
      check("midrst.active", play_active, 0);
      // start held high: only one game start
      start = 1'b1;
      step(1);
      expect_hud("held", 1, 1, 3, 0);
      step(2);
      step(4);
      check("held.tick", time_left, 4);
      step(1);
      crash = 1'b1;
      step(1);
      crash = 1'b0;
      check("held.c1", lives, 2);
      crash_once("held.c2", 1, 1);
      crash_once("held.c3", 5, 0);
      step(3);
      check("held.no_restart", game_state, 5);
      start = 1'b0;
      step(1);
      check("held.released", game_state, 5);
      start = 1'b1;
      step(1);
      start = 1'b0;
      expect_hud("held.restart", 1, 1, 3, 5);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
